// File: rtl/fifo_pkg.sv
// Shared definitions for the synchronous FIFO and its read-side controller.
package fifo_pkg;

  localparam int DEF_FIFO_WIDTH = 16;
  localparam int DEF_FIFO_DEPTH = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } rd_state_e;

endpackage

// File: rtl/fifo_reader_if.sv
// FIFO read port plus the valid/ready output stream of the reader.
// master = the reader, slave = the FIFO/consumer side.
interface fifo_reader_if
  import fifo_pkg::*;
#(
  parameter int FIFO_WIDTH = DEF_FIFO_WIDTH
) ();

  logic                  fifo_empty;
  logic                  fifo_underflow;
  logic [FIFO_WIDTH-1:0] fifo_data_out;
  logic                  fifo_rd_en;
  logic                  m_valid;
  logic [FIFO_WIDTH-1:0] m_data;
  logic                  m_ready;

  modport master (
    input  fifo_empty,
    input  fifo_underflow,
    input  fifo_data_out,
    input  m_ready,
    output fifo_rd_en,
    output m_valid,
    output m_data
  );

  modport slave (
    output fifo_empty,
    output fifo_underflow,
    output fifo_data_out,
    output m_ready,
    input  fifo_rd_en,
    input  m_valid,
    input  m_data
  );

endinterface

// File: rtl/fifo_reader_buf.sv
// Small circular buffer that absorbs the FIFO read latency.
// Write and pop in the same cycle are allowed, including when full.
module fifo_reader_buf #(
  parameter int W     = 16,
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr,
  input  logic [W-1:0]  wdata,
  input  logic          pop,
  output logic [W-1:0]  head,
  output logic [CW-1:0] cnt
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_wr, do_pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Next-state for pointers and occupancy; a write into a full buffer is
  // only taken when a pop frees the head slot in the same cycle.
  always_comb begin
    do_pop   = pop && (cnt_q != '0);
    do_wr    = wr && ((cnt_q < CW'(DEPTH)) || do_pop);
    rd_ptr_d = do_pop ? next_ptr(rd_ptr_q) : rd_ptr_q;
    wr_ptr_d = do_wr  ? next_ptr(wr_ptr_q) : wr_ptr_q;
    case ({do_wr, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Control registers: pointers and count, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage: data only, no reset needed since cnt gates visibility.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr_q] <= wdata;
  end

  assign head = mem[rd_ptr_q];
  assign cnt  = cnt_q;

endmodule

// File: rtl/fifo_reader.sv
// Read-side controller: issues FIFO reads, captures returned words one cycle
// later into a small buffer, and presents them on a valid/ready stream.
module fifo_reader
  import fifo_pkg::*;
#(
  parameter int FIFO_WIDTH = DEF_FIFO_WIDTH,
  parameter int BUF_DEPTH  = 2,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             drain_en,
  fifo_reader_if.master    bus,
  output logic             busy,
  output logic [CNT_W-1:0] words_read,
  output logic             err_underflow
);

  localparam int             CW        = $clog2(BUF_DEPTH + 1);
  localparam logic [CW:0]    DEPTH_LIM = (CW + 1)'(BUF_DEPTH);

  rd_state_e             state_q, state_d;
  logic                  inflight_q, inflight_d;
  logic [CNT_W-1:0]      words_read_q, words_read_d;
  logic                  err_q, err_d;

  logic [CW-1:0]         buf_cnt;
  logic [FIFO_WIDTH-1:0] buf_head;
  logic                  m_valid;
  logic                  pop, wr, rd_en;
  logic [CW:0]           occ;

  fifo_reader_buf #(
    .W     (FIFO_WIDTH),
    .DEPTH (BUF_DEPTH),
    .CW    (CW)
  ) u_buf (
    .clk   (clk),
    .rst   (rst),
    .wr    (wr),
    .wdata (bus.fifo_data_out),
    .pop   (pop),
    .head  (buf_head),
    .cnt   (buf_cnt)
  );

  // Read issue: only request when the word already owed (buffered + in flight,
  // less the one leaving this cycle) still leaves room for another.
  always_comb begin
    m_valid = (buf_cnt != '0);
    pop     = m_valid && bus.m_ready;
    wr      = inflight_q && !bus.fifo_underflow;
    occ     = {1'b0, buf_cnt} + {{CW{1'b0}}, inflight_q} - {{CW{1'b0}}, pop};
    rd_en   = (state_q == RUN) && !bus.fifo_empty && (occ < DEPTH_LIM);
  end

  // FSM next state plus counter, in-flight flag and sticky error next values.
  always_comb begin
    state_d      = state_q;
    inflight_d   = rd_en;
    words_read_d = pop ? words_read_q + 1'b1 : words_read_q;
    err_d        = err_q | (inflight_q & bus.fifo_underflow);
    case (state_q)
      IDLE:    if (drain_en) state_d = RUN;
      RUN:     if (!drain_en) state_d = FLUSH;
      FLUSH: begin
        if (drain_en)                              state_d = RUN;
        else if (!inflight_q && (buf_cnt == '0))   state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      inflight_q   <= 1'b0;
      words_read_q <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      inflight_q   <= inflight_d;
      words_read_q <= words_read_d;
      err_q        <= err_d;
    end
  end

  assign bus.fifo_rd_en = rd_en;
  assign bus.m_valid    = m_valid;
  assign bus.m_data     = m_valid ? buf_head : '0;
  assign busy           = (state_q != IDLE);
  assign words_read     = words_read_q;
  assign err_underflow  = err_q;

endmodule

// File: tb/tb_fifo_reader.sv
// Bench for fifo_reader: a behavioural FIFO feeds the reader, a scoreboard
// queue holds expected words and a negedge monitor checks the stream.
module tb_fifo_reader;

  logic       clk = 1'b0;
  logic       rst;
  logic       drain_en;
  logic       busy;
  logic [3:0] words_read;
  logic       err_underflow;

  always #5 clk = ~clk;

  fifo_reader_if #(.FIFO_WIDTH(16)) bus ();

  fifo_reader #(
    .FIFO_WIDTH (16),
    .BUF_DEPTH  (2),
    .CNT_W      (4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .drain_en      (drain_en),
    .bus           (bus),
    .busy          (busy),
    .words_read    (words_read),
    .err_underflow (err_underflow)
  );

  int errors = 0;
  int checks = 0;

  logic [15:0] exp_q [$];

  // Behavioural FIFO: memory/write pointer owned by stimulus, read side here.
  logic [15:0] fmem [256];
  int          wr_ptr     = 0;
  int          rd_ptr     = 0;
  int          poison_idx = -1;

  assign bus.fifo_empty = (rd_ptr == wr_ptr);

  always @(posedge clk) begin
    bus.fifo_underflow <= 1'b0;
    if (bus.fifo_rd_en) begin
      if (rd_ptr == wr_ptr) begin
        bus.fifo_underflow <= 1'b1;
      end else begin
        bus.fifo_data_out <= fmem[rd_ptr];
        if (rd_ptr == poison_idx) bus.fifo_underflow <= 1'b1;
        rd_ptr <= rd_ptr + 1;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [15:0] w, input bit expect_it);
    fmem[wr_ptr] = w;
    if (expect_it) exp_q.push_back(w);
    wr_ptr++;
  endtask

  task automatic wait_drain(input string name, input int max_cycles);
    int n = 0;
    while (exp_q.size() != 0 && n < max_cycles) begin
      step();
      n++;
    end
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic wait_rd_en(input string name, input int max_cycles);
    int n = 0;
    while (!bus.fifo_rd_en && n < max_cycles) begin
      step();
      n++;
    end
    check(name, 32'(bus.fifo_rd_en), 32'd1);
  endtask

  // Monitor: ordering, stall stability, counter tracking, no read while empty.
  logic [3:0]  exp_cnt   = '0;
  bit          prev_stall = 1'b0;
  logic [15:0] prev_data  = '0;

  always @(negedge clk) begin
    if (rst) begin
      check("rst_m_valid", 32'(bus.m_valid), 32'd0);
      check("rst_words_read", 32'(words_read), 32'd0);
      exp_cnt    = '0;
      prev_stall = 1'b0;
    end else begin
      check("rd_en_while_empty", 32'(bus.fifo_rd_en && bus.fifo_empty), 32'd0);
      check("words_read_track", 32'(words_read), 32'(exp_cnt));
      if (prev_stall) begin
        check("stall_valid", 32'(bus.m_valid), 32'd1);
        check("stall_data", 32'(bus.m_data), 32'(prev_data));
      end
      if (bus.m_valid && bus.m_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word: got 0x%0h expected none at %0t", bus.m_data, $time);
        end else begin
          check("m_data_order", 32'(bus.m_data), 32'(exp_q.pop_front()));
        end
        exp_cnt = exp_cnt + 1'b1;
      end
      prev_stall = bus.m_valid && !bus.m_ready;
      prev_data  = bus.m_data;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit [3:0] pat;
    pat         = 4'b1001;
    rst         = 1'b1;
    drain_en    = 1'b0;
    bus.m_ready = 1'b0;
    repeat (3) step();

    // Reset state
    check("reset_rd_en", 32'(bus.fifo_rd_en), 32'd0);
    check("reset_m_valid", 32'(bus.m_valid), 32'd0);
    check("reset_m_data", 32'(bus.m_data), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_words_read", 32'(words_read), 32'd0);
    check("reset_err", 32'(err_underflow), 32'd0);
    rst = 1'b0;
    step();

    // 1: eight words at full rate
    for (int i = 1; i <= 8; i++) load(16'(i), 1'b1);
    bus.m_ready = 1'b1;
    drain_en    = 1'b1;
    wait_rd_en("t1_rd_en", 10);
    step();
    step();
    check("t1_latency_valid", 32'(bus.m_valid), 32'd1);
    repeat (7) step();
    check("t1_throughput_left", 32'(exp_q.size()), 32'd1);
    step();
    check("t1_all_delivered", 32'(exp_q.size()), 32'd0);
    check("t1_words_read", 32'(words_read), 32'd8);
    check("t1_busy_running", 32'(busy), 32'd1);
    drain_en = 1'b0;
    repeat (3) step();
    check("t1_busy_idle", 32'(busy), 32'd0);

    // 2: back-pressure pattern 1,0,0,1
    for (int i = 0; i < 8; i++) load(16'h0011 + 16'(i), 1'b1);
    drain_en = 1'b1;
    for (int i = 0; i < 80 && exp_q.size() != 0; i++) begin
      bus.m_ready = pat[i % 4];
      step();
    end
    check("t2_drained", 32'(exp_q.size()), 32'd0);
    check("t2_words_read", 32'(words_read), 32'd0);
    bus.m_ready = 1'b1;
    drain_en    = 1'b0;
    repeat (3) step();
    check("t2_busy_idle", 32'(busy), 32'd0);

    // 3: drain_en drops one cycle after the first read
    for (int i = 0; i < 4; i++) load(16'h0031 + 16'(i), (i < 2));
    drain_en = 1'b1;
    wait_rd_en("t3_rd_en", 10);
    step();
    drain_en = 1'b0;
    step();
    for (int i = 0; i < 6; i++) begin
      check("t3_no_more_reads", 32'(bus.fifo_rd_en), 32'd0);
      step();
    end
    check("t3_idle", 32'(busy), 32'd0);
    check("t3_inflight_delivered", 32'(exp_q.size()), 32'd0);
    check("t3_fifo_left", 32'(wr_ptr - rd_ptr), 32'd2);

    // 4: reset with 0x33/0x34 buffered; delivery resumes at 0x41
    load(16'h0041, 1'b1);
    load(16'h0042, 1'b1);
    bus.m_ready = 1'b0;
    drain_en    = 1'b1;
    repeat (6) step();
    check("t4_buf_head", 32'(bus.m_data), 32'h33);
    check("t4_full_no_reads", 32'(wr_ptr - rd_ptr), 32'd2);
    rst = 1'b1;
    #1;
    check("t4_async_m_valid", 32'(bus.m_valid), 32'd0);
    check("t4_async_m_data", 32'(bus.m_data), 32'd0);
    check("t4_async_words_read", 32'(words_read), 32'd0);
    check("t4_async_busy", 32'(busy), 32'd0);
    step();
    rst         = 1'b0;
    bus.m_ready = 1'b1;
    wait_drain("t4_resume", 30);
    check("t4_words_read", 32'(words_read), 32'd2);
    drain_en = 1'b0;
    repeat (3) step();

    // 5: underflow reported on a read: word dropped, sticky error
    poison_idx = wr_ptr;
    load(16'h0050, 1'b0);
    drain_en = 1'b1;
    repeat (5) step();
    check("t5_err_set", 32'(err_underflow), 32'd1);
    check("t5_dropped", 32'(bus.m_valid), 32'd0);
    check("t5_words_read", 32'(words_read), 32'd2);
    load(16'h0051, 1'b1);
    wait_drain("t5_next_word", 20);
    check("t5_err_sticky", 32'(err_underflow), 32'd1);
    drain_en = 1'b0;
    repeat (3) step();
    rst = 1'b1;
    step();
    check("t5_err_cleared", 32'(err_underflow), 32'd0);
    rst = 1'b0;
    step();

    // 6: 17 words through a 4-bit counter
    for (int i = 0; i < 17; i++) load(16'h0060 + 16'(i), 1'b1);
    drain_en = 1'b1;
    wait_drain("t6_drained", 60);
    check("t6_words_read_wrap", 32'(words_read), 32'd1);
    drain_en = 1'b0;
    repeat (3) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
